uart_msg_assembler: RTL and testbench
=====================================

// Module: uart_msg_assembler
// PURPOSE
//  Upstream neighbour of the controller's UART input FIFO. Takes the byte stream from the UART receiver and
//  packs MSG_BYTES consecutive bytes into one `UART_MSG_SIZE message, then writes it to the input FIFO.
//  Drops partial messages on inter-byte timeout or framing error and resynchronises on line idle.
//  Reports drops so the host can tell lost commands from ignored ones.
// PARAMETERS
//  MSG_BYTES      `UART_MSG_WIDTH/8  bytes per message; `UART_MSG_WIDTH must be a multiple of 8
//  TIMEOUT_CYCLES 10000              max clk cycles between bytes of one message; also the idle time for resync
//  CNT_W          $clog2(TIMEOUT_CYCLES+1)  timeout counter width
// PORTS
//  clk            in   1           system clock
//  reset          in   1           synchronous, active-high reset
//  rx_byte        in   8           received byte, valid with rx_valid
//  rx_valid       in   1           one-cycle strobe: rx_byte is new
//  rx_err         in   1           one-cycle strobe: framing/parity error on current byte (byte is invalid)
//  fifo_full      in   1           input FIFO full
//  fifo_msg       out  8*MSG_BYTES assembled message, registered
//  fifo_wr        out  1           one-cycle write strobe to input FIFO
//  msg_dropped    out  1           one-cycle pulse: complete message discarded, FIFO full
//  timeout_err    out  1           one-cycle pulse: partial message discarded (timeout or rx_err)
//  drop_count     out  8           saturating count of all discarded messages (complete + partial)
// BEHAVIOUR
//  Reset: state=IDLE, byte index 0, counter 0; fifo_msg=0, fifo_wr=0, msg_dropped=0, timeout_err=0, drop_count=0.
//  Packing: byte k of a message goes to bits [8k+7:8k]; byte 0 (first on the wire) holds the header low bits.
//  States:
//   IDLE    - rx_valid: store byte 0, idx=1, counter=0 -> COLLECT (-> complete immediately if MSG_BYTES==1).
//             rx_err: -> RESYNC.
//   COLLECT - rx_valid: store byte idx, idx++, counter=0. Last byte (idx==MSG_BYTES-1): -> IDLE and complete.
//             rx_err: discard partial, timeout_err=1, drop_count++ -> RESYNC.
//             counter reaches TIMEOUT_CYCLES with no rx_valid: discard, timeout_err=1, drop_count++ -> IDLE.
//             rx_valid in the expiry cycle: the byte wins and the counter reloads. No timeout is raised.
//   RESYNC  - counter counts idle cycles. Any rx_valid/rx_err restarts it (the byte is discarded).
//             At TIMEOUT_CYCLES -> IDLE.
//  Completion: the cycle after the last byte is accepted, the assembly register is copied to fifo_msg.
//   If fifo_full=0 in that cycle: fifo_wr=1. Otherwise: msg_dropped=1, drop_count++, no write.
//   fifo_full is sampled in the completion cycle only; there is no retry or buffering.
//  Latency: last rx_valid at cycle N -> fifo_wr at N+1. fifo_msg stays stable until the next completion.
//  Back-to-back: the assembly register is separate from fifo_msg, so a byte that arrives in the completion
//   cycle is accepted as byte 0 of the next message. No byte loss at line rate.
//  rx_valid and rx_err in the same cycle: rx_err wins and the byte is discarded.
//  drop_count saturates at 8'hFF and is cleared only by reset.
//  msg_dropped and timeout_err are never both high in the same cycle. If a completion-drop and a partial-drop
//   coincide, drop_count increments by 2 (still saturating).
//  Reset mid-message: the partial message is lost silently, with no pulses and no count.
//  The block does not interpret header contents; invalid headers are handled downstream.
// STRUCTURE
//  Shared header uart_msg_consts.h: `UART_MSG_WIDTH, `UART_MSG_SIZE (already present).
//  Add to test_harness_consts.h: `DEFAULT_RX_TIMEOUT_CYCLES.
//  State encoding: localparams local to this module.
//  One natural sub-module: uart_rx_timer, a reloadable idle counter with expiry flag (ports clk, reset,
//   restart, expired). It serves both COLLECT and RESYNC.
//  Everything else (packing shift/index register, output register, drop counter) lives in this module.
// TESTING
//  1 MSG_BYTES=4, send 8'h01,8'h22,8'h33,8'h44 back-to-back, fifo_full=0 -> fifo_wr once,
//    fifo_msg=32'h44332201, exactly 1 cycle after the 4th byte.
//  2 Two messages with no gap (8 consecutive strobes) -> two fifo_wr pulses 4 cycles apart, both correct,
//    drop_count=0.
//  3 TIMEOUT_CYCLES=16: send 2 bytes then wait 16 cycles -> timeout_err pulses, drop_count=1.
//    Next 4 bytes form a correct message.
//  4 fifo_full=1 during the completion cycle -> no fifo_wr, msg_dropped=1, drop_count+1.
//    fifo_full=1 while collecting but 0 at completion -> normal write.
//  5 rx_err after byte 1 -> timeout_err, RESYNC. Bytes sent with <16-cycle gaps are ignored.
//    After 16 idle cycles, a new message is assembled correctly.
//  6 Force 300 drops -> drop_count holds 8'hFF. Assert reset mid-message -> all outputs 0,
//    and the next full message is assembled from byte 0.

Source files
------------

// File: rtl/uart_msg_assembler_pkg.sv
// uart_msg_assembler_pkg
//   Shared types and constants for the UART message assembler slice.
//   UART_MSG_WIDTH            : width of one assembled message in bits (multiple of 8)
//   DEFAULT_RX_TIMEOUT_CYCLES : default inter-byte timeout / resync idle time in clk cycles
//   asm_state_t               : assembler FSM states
//   sat_add8                  : 8-bit saturating add of a 0..3 increment
package uart_msg_assembler_pkg;

   localparam int unsigned UART_MSG_WIDTH            = 32;
   localparam int unsigned DEFAULT_RX_TIMEOUT_CYCLES = 10000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_RESYNC  = 2'd2
   } asm_state_t;

   function automatic logic [7:0] sat_add8(input logic [7:0] i_val, input logic [1:0] i_inc);
      logic [8:0] w_sum;
      w_sum = {1'b0, i_val} + {7'b0, i_inc};
      return w_sum[8] ? 8'hFF : w_sum[7:0];
   endfunction

endpackage

// File: rtl/uart_rx_timer.sv
// uart_rx_timer
//   Reloadable idle counter. Counts clk cycles since the last restart and
//   holds at TIMEOUT_CYCLES, raising expired while it sits there.
//   clk     : system clock
//   reset   : synchronous active-high reset (counter -> 0)
//   restart : reload the counter to 0 on the next edge
//   expired : counter has reached TIMEOUT_CYCLES
module uart_rx_timer
   import uart_msg_assembler_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_RX_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         r_cnt <= '0;
      end else if (r_cnt != LIMIT) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign expired = (r_cnt == LIMIT);

endmodule

// File: rtl/uart_msg_assembler.sv
// uart_msg_assembler
//   Packs MSG_BYTES consecutive UART bytes into one message (byte k -> bits
//   [8k+7:8k]) and writes it to the controller input FIFO. Partial messages
//   are dropped on inter-byte timeout or rx_err; after rx_err the line must
//   stay idle for TIMEOUT_CYCLES before a new message is accepted.
//   clk         : system clock
//   reset       : synchronous active-high reset
//   rx_byte     : received byte, valid with rx_valid
//   rx_valid    : one-cycle strobe, rx_byte is new
//   rx_err      : one-cycle strobe, framing/parity error (wins over rx_valid)
//   fifo_full   : input FIFO full, sampled in the completion cycle only
//   fifo_msg    : last completed message, registered, stable until next completion
//   fifo_wr     : one-cycle FIFO write strobe
//   msg_dropped : one-cycle pulse, complete message discarded because FIFO full
//   timeout_err : one-cycle pulse, partial message discarded
//   drop_count  : saturating count of all discarded messages
module uart_msg_assembler
   import uart_msg_assembler_pkg::*;
#(
   parameter int unsigned MSG_BYTES      = UART_MSG_WIDTH / 8,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_RX_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             rx_byte,
   input  logic                   rx_valid,
   input  logic                   rx_err,
   input  logic                   fifo_full,
   output logic [8*MSG_BYTES-1:0] fifo_msg,
   output logic                   fifo_wr,
   output logic                   msg_dropped,
   output logic                   timeout_err,
   output logic [7:0]             drop_count
);

   localparam int unsigned      IDX_W    = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_BYTES - 1);

   asm_state_t             r_state;
   asm_state_t             w_next_state;
   logic [IDX_W-1:0]       r_idx;
   logic [8*MSG_BYTES-1:0] r_asm;
   logic [8*MSG_BYTES-1:0] w_asm_next;
   logic                   r_complete;
   logic [7:0]             r_drop_count;

   logic                   w_store;
   logic                   w_last;
   logic                   w_part_drop;
   logic                   w_cmp_drop;
   logic [1:0]             w_drop_inc;
   logic                   w_restart;
   logic                   w_expired;

   // The timer only matters in COLLECT and RESYNC; holding it at 0 in IDLE
   // means the first byte of a message always starts from a fresh count.
   assign w_restart = rx_valid | rx_err | (r_state == ST_IDLE);

   uart_rx_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (w_restart),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_store      = 1'b0;
      w_last       = 1'b0;
      w_part_drop  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (rx_err) begin
               w_next_state = ST_RESYNC;
            end else if (rx_valid) begin
               w_store = 1'b1;
               if (MSG_BYTES == 1) begin
                  w_last = 1'b1;
               end else begin
                  w_next_state = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (rx_err) begin
               w_part_drop  = 1'b1;
               w_next_state = ST_RESYNC;
            end else if (rx_valid) begin
               // A byte arriving in the expiry cycle is taken; the timeout is not raised.
               w_store = 1'b1;
               if (r_idx == IDX_LAST) begin
                  w_last       = 1'b1;
                  w_next_state = ST_IDLE;
               end
            end else if (w_expired) begin
               w_part_drop  = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         ST_RESYNC: begin
            if (!rx_valid && !rx_err && w_expired) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // r_idx is 0 whenever the FSM is in IDLE, so it also addresses byte 0 there.
   always_comb begin
      w_asm_next = r_asm;
      for (int unsigned k = 0; k < MSG_BYTES; k++) begin
         if (w_store && (r_idx == IDX_W'(k))) begin
            w_asm_next[8*k +: 8] = rx_byte;
         end
      end
   end

   assign w_cmp_drop = r_complete & fifo_full;
   assign w_drop_inc = {1'b0, w_cmp_drop} + {1'b0, w_part_drop};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx        <= '0;
         r_asm        <= '0;
         r_complete   <= 1'b0;
         fifo_msg     <= '0;
         r_drop_count <= '0;
      end else begin
         r_asm      <= w_asm_next;
         r_complete <= w_last;
         if (w_last) begin
            fifo_msg <= w_asm_next;
         end
         if (w_last || w_part_drop) begin
            r_idx <= '0;
         end else if (w_store) begin
            r_idx <= r_idx + IDX_W'(1);
         end
         r_drop_count <= sat_add8(r_drop_count, w_drop_inc);
      end
   end

   // Strobes are gated by reset so a mid-message reset produces no pulses.
   assign fifo_wr     = r_complete & ~fifo_full & ~reset;
   assign msg_dropped = w_cmp_drop & ~reset;
   assign timeout_err = w_part_drop & ~reset;
   assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_uart_msg_assembler.sv
// tb_uart_msg_assembler
//   Self-checking bench for uart_msg_assembler with MSG_BYTES=4, TIMEOUT_CYCLES=16.
//   Inputs change 1 time unit after the rising edge; the monitor samples on the
//   falling edge and checks every fifo_wr against a scoreboard of expected
//   {message, cycle} entries pushed when the last byte is driven.
module tb_uart_msg_assembler;

   localparam int unsigned MB = 4;
   localparam int unsigned TO = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [7:0]      rx_byte = '0;
   logic            rx_valid = 1'b0;
   logic            rx_err = 1'b0;
   logic            fifo_full = 1'b0;
   logic [8*MB-1:0] fifo_msg;
   logic            fifo_wr;
   logic            msg_dropped;
   logic            timeout_err;
   logic [7:0]      drop_count;

   uart_msg_assembler #(
      .MSG_BYTES      (MB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_byte     (rx_byte),
      .rx_valid    (rx_valid),
      .rx_err      (rx_err),
      .fifo_full   (fifo_full),
      .fifo_msg    (fifo_msg),
      .fifo_wr     (fifo_wr),
      .msg_dropped (msg_dropped),
      .timeout_err (timeout_err),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;
   int unsigned n_wr    = 0;
   int unsigned n_mdrop = 0;
   int unsigned n_terr  = 0;

   typedef struct {
      logic [31:0] msg;
      int unsigned cyc;
   } exp_t;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (fifo_wr) begin
         n_wr++;
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_wr: got write of %h at cycle %0d, required no write", fifo_msg, cyc);
         end else begin
            e = sb.pop_front();
            if (fifo_msg !== e.msg || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL sb_write: got %h at cycle %0d, required %h at cycle %0d",
                        fifo_msg, cyc, e.msg, e.cyc);
            end
         end
      end
      if (msg_dropped) n_mdrop++;
      if (timeout_err) n_terr++;
      if (msg_dropped || timeout_err) begin
         n_tests++;
         if (msg_dropped && timeout_err) begin
            n_fail++;
            $display("FAIL pulse_overlap: got msg_dropped=1 timeout_err=1, required not both");
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Sends one message with 'gap' idle cycles between bytes, then holds
   // fifo_full=full_done for the completion cycle.
   task automatic send_msg(input logic [31:0] m, input int unsigned gap,
                           input bit full_collect, input bit full_done);
      fifo_full = full_collect;
      for (int k = 0; k < 4; k++) begin
         rx_byte  = m[8*k +: 8];
         rx_valid = 1'b1;
         if (k == 3 && !full_done) sb.push_back('{msg: m, cyc: cyc + 1});
         step();
         rx_valid = 1'b0;
         if (k < 3) repeat (gap) step();
      end
      fifo_full = full_done;
      step();
      fifo_full = 1'b0;
   endtask

   typedef struct {
      logic [31:0] msg;
      int unsigned gap;
      bit          full_collect;
      bit          full_done;
      logic [7:0]  exp_drops;
   } vec_t;

   vec_t        vecs[7];
   int unsigned md0;
   int unsigned t0;
   int unsigned w0;
   logic [7:0]  exp_dc;

   initial begin
      vecs[0] = '{msg: 32'h44332201, gap: 0,  full_collect: 0, full_done: 0, exp_drops: 8'd0};
      vecs[1] = '{msg: 32'hA5A55A5A, gap: 3,  full_collect: 0, full_done: 0, exp_drops: 8'd0};
      vecs[2] = '{msg: 32'hDEADBEEF, gap: 5,  full_collect: 1, full_done: 0, exp_drops: 8'd0};
      vecs[3] = '{msg: 32'h01020304, gap: 15, full_collect: 0, full_done: 0, exp_drops: 8'd0};
      vecs[4] = '{msg: 32'h9ABCDEF0, gap: 16, full_collect: 0, full_done: 0, exp_drops: 8'd0};
      vecs[5] = '{msg: 32'hCAFEF00D, gap: 1,  full_collect: 0, full_done: 1, exp_drops: 8'd1};
      vecs[6] = '{msg: 32'h00000000, gap: 0,  full_collect: 1, full_done: 1, exp_drops: 8'd2};

      repeat (3) step();
      check("rst_fifo_msg", fifo_msg, 32'h0);
      check("rst_fifo_wr", {31'b0, fifo_wr}, 32'h0);
      check("rst_msg_dropped", {31'b0, msg_dropped}, 32'h0);
      check("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
      check("rst_drop_count", {24'b0, drop_count}, 32'h0);
      reset = 1'b0;
      step();

      // Table: single messages with varied gaps (15 and 16 are the timeout boundary) and FIFO states.
      foreach (vecs[i]) begin
         md0 = n_mdrop;
         send_msg(vecs[i].msg, vecs[i].gap, vecs[i].full_collect, vecs[i].full_done);
         check($sformatf("vec%0d_fifo_msg", i), fifo_msg, vecs[i].msg);
         check($sformatf("vec%0d_drops", i), {24'b0, drop_count}, {24'b0, vecs[i].exp_drops});
         check($sformatf("vec%0d_msg_dropped", i), n_mdrop - md0, {31'b0, vecs[i].full_done});
      end
      check("table_no_timeout", n_terr, 32'd0);
      exp_dc = 8'd2;

      // Two messages, eight consecutive strobes.
      w0 = n_wr;
      for (int k = 0; k < 8; k++) begin
         rx_byte  = 8'h10 + 8'(k);
         rx_valid = 1'b1;
         if (k == 3) sb.push_back('{msg: 32'h13121110, cyc: cyc + 1});
         if (k == 7) sb.push_back('{msg: 32'h17161514, cyc: cyc + 1});
         step();
      end
      rx_valid = 1'b0;
      repeat (2) step();
      check("b2b_writes", n_wr - w0, 32'd2);
      check("b2b_drops", {24'b0, drop_count}, {24'b0, exp_dc});

      // Inter-byte timeout after 2 bytes.
      t0 = n_terr;
      rx_byte = 8'hA0; rx_valid = 1'b1; step();
      rx_byte = 8'hA1; step();
      rx_valid = 1'b0;
      repeat (TO - 1) step();
      check("t3_no_early_timeout", n_terr - t0, 32'd0);
      check("t3_early_level", {31'b0, timeout_err}, 32'h0);
      step();
      check("t3_timeout_err", {31'b0, timeout_err}, 32'h1);
      step();
      exp_dc = exp_dc + 8'd1;
      check("t3_timeout_count", n_terr - t0, 32'd1);
      check("t3_drops", {24'b0, drop_count}, {24'b0, exp_dc});
      send_msg(32'h87654321, 0, 0, 0);
      check("t3_next_msg", fifo_msg, 32'h87654321);

      // rx_err with rx_valid after two bytes, then junk during resync.
      t0 = n_terr;
      rx_byte = 8'h11; rx_valid = 1'b1; step();
      rx_byte = 8'h22; step();
      rx_byte = 8'h33; rx_err = 1'b1; step();
      rx_valid = 1'b0; rx_err = 1'b0;
      exp_dc = exp_dc + 8'd1;
      check("t5_timeout_err", n_terr - t0, 32'd1);
      check("t5_drops", {24'b0, drop_count}, {24'b0, exp_dc});
      w0 = n_wr;
      for (int k = 0; k < 6; k++) begin
         rx_byte = 8'h50 + 8'(k);
         if (k == 3) rx_err = 1'b1;
         else        rx_valid = 1'b1;
         step();
         rx_valid = 1'b0; rx_err = 1'b0;
         repeat (10) step();
      end
      repeat (TO + 1 - 10) step();
      check("t5_resync_no_write", n_wr - w0, 32'd0);
      check("t5_resync_no_timeout", n_terr - t0, 32'd1);
      send_msg(32'hC0FFEE01, 2, 0, 0);
      check("t5_after_resync", fifo_msg, 32'hC0FFEE01);

      // Saturation: 300 completion drops.
      md0 = n_mdrop;
      fifo_full = 1'b1;
      for (int m = 0; m < 300; m++) begin
         for (int k = 0; k < 4; k++) begin
            rx_byte  = 8'(k);
            rx_valid = 1'b1;
            step();
         end
      end
      rx_valid = 1'b0;
      step();
      fifo_full = 1'b0;
      step();
      check("sat_pulses", n_mdrop - md0, 32'd300);
      check("sat_drop_count", {24'b0, drop_count}, 32'h000000FF);

      // Reset in the middle of a message.
      t0 = n_terr;
      rx_byte = 8'hEE; rx_valid = 1'b1; step(); step();
      rx_valid = 1'b0;
      reset = 1'b1; step();
      reset = 1'b0;
      check("mid_rst_fifo_msg", fifo_msg, 32'h0);
      check("mid_rst_fifo_wr", {31'b0, fifo_wr}, 32'h0);
      check("mid_rst_msg_dropped", {31'b0, msg_dropped}, 32'h0);
      check("mid_rst_timeout_err", {31'b0, timeout_err}, 32'h0);
      check("mid_rst_drop_count", {24'b0, drop_count}, 32'h0);
      send_msg(32'h0BADF00D, 0, 0, 0);
      check("mid_rst_next_msg", fifo_msg, 32'h0BADF00D);
      check("mid_rst_no_pulse", n_terr - t0, 32'd0);
      check("mid_rst_drops_after", {24'b0, drop_count}, 32'h0);

      repeat (2) step();
      check("sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish by time limit, required finish");
      $fatal(1);
   end

endmodule
